// File: rtl/ept_collector_pkg.sv
// Shared types and default sizing for the endpoint collector blocks.
package ept_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_LEVEL_WIDTH = DEF_ADDR_WIDTH + 1;
  localparam int DEF_TIMEOUT     = 255;

  // Width of a counter that must be able to hold the value `timeout`.
  function automatic int timer_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int DEF_TIMER_WIDTH = timer_width(DEF_TIMEOUT);

endpackage

// File: rtl/ept_idle_timer.sv
// Saturating idle counter; expired stays high while the count sits at the saturate value.
module ept_idle_timer
  import ept_collector_pkg::*;
#(
  parameter int WIDTH = DEF_TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] saturate,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != saturate)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == saturate);

endmodule

// File: rtl/ept_burst_drain_ctrl.sv
// Drains a FIFO to a host in bursts of up to BURST words, forcing a partial
// burst after TIMEOUT idle cycles and supporting a flush that truncates bursts.
module ept_burst_drain_ctrl
  import ept_collector_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int BURST      = 8,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH:0]   write_ptr,
  output logic [ADDR_WIDTH:0]   read_ptr,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_valid,
  input  logic                  host_ready,
  output logic                  host_last,
  input  logic                  flush_req,
  output logic                  flush,
  output logic                  burst_abort,
  output logic                  busy
);

  localparam int LW        = ADDR_WIDTH + 1;
  localparam int TW        = timer_width(TIMEOUT);
  localparam int BURST_EFF = (BURST > DEPTH) ? DEPTH : BURST;
  localparam logic [LW-1:0] BURST_LVL   = LW'(BURST_EFF);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [LW-1:0] level;
  logic [LW-1:0] remaining;
  logic          abort_pend;
  logic          from_xfer;
  logic          expired;
  logic          handshake;
  logic          start;
  logic          abort_go;
  logic          timer_clear;

  // Modular subtraction keeps the fill level correct across pointer wrap.
  assign level     = write_ptr - read_ptr;
  assign handshake = host_valid && host_ready;
  assign start     = enable && !flush_req &&
                     ((level >= BURST_LVL) || ((level != '0) && expired));

  // A fresh flush request blocks reads in the same cycle so no word read after it
  // can be tagged as the last of the burst.
  assign read_enable = (state == ST_XFER) && (remaining != '0) && (level != '0) &&
                       !abort_pend && !flush_req && (!host_valid || host_ready);

  // An abort waits until no word is left unaccepted on the host side.
  assign abort_go = (abort_pend || flush_req) && (!host_valid || host_ready);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush_req)  state_nxt = ST_FLUSH;
        else if (start) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (abort_go)                     state_nxt = ST_FLUSH;
        else if (handshake && host_last)  state_nxt = ST_IDLE;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      read_ptr   <= '0;
      remaining  <= '0;
      host_data  <= '0;
      host_valid <= 1'b0;
      host_last  <= 1'b0;
      abort_pend <= 1'b0;
      from_xfer  <= 1'b0;
    end else begin
      state     <= state_nxt;
      from_xfer <= (state == ST_XFER) && (state_nxt == ST_FLUSH);

      if ((state == ST_IDLE) && (state_nxt == ST_XFER)) begin
        remaining <= (level < BURST_LVL) ? level : BURST_LVL;
      end else if (read_enable) begin
        remaining <= remaining - 1'b1;
      end

      if (state_nxt != ST_XFER) begin
        abort_pend <= 1'b0;
      end else if (flush_req) begin
        abort_pend <= 1'b1;
      end

      if (state == ST_FLUSH) begin
        read_ptr <= '0;
      end else if (read_enable) begin
        read_ptr <= read_ptr + 1'b1;
      end

      if (read_enable) begin
        host_data  <= fifo_rdata;
        host_valid <= 1'b1;
        host_last  <= (remaining == LW'(1));
      end else if (handshake) begin
        host_valid <= 1'b0;
        host_last  <= 1'b0;
      end
    end
  end

  assign timer_clear = (state != ST_IDLE) || (state_nxt != ST_IDLE) || (level == '0);

  ept_idle_timer #(
    .WIDTH (TW)
  ) u_idle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .count_en (level < BURST_LVL),
    .saturate (TIMEOUT_CNT),
    .expired  (expired)
  );

  assign flush       = (state == ST_FLUSH);
  assign burst_abort = (state == ST_FLUSH) && from_xfer;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ept_burst_drain_ctrl.sv
// Directed bench for ept_burst_drain_ctrl with a small FIFO model on the read side.
module tb_ept_burst_drain_ctrl;

  localparam int AW      = 4;
  localparam int LW      = AW + 1;
  localparam int DW      = 8;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [LW-1:0] write_ptr;
  logic [LW-1:0] read_ptr;
  logic          read_enable;
  logic [DW-1:0] fifo_rdata;
  logic [DW-1:0] host_data;
  logic          host_valid;
  logic          host_ready;
  logic          host_last;
  logic          flush_req;
  logic          flush;
  logic          burst_abort;
  logic          busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  // Per-scenario activity log, filled at the falling edge.
  int cyc, re_cnt, held_re, zero_re, flush_cnt, abort_cnt, unstable, stall_cnt, acc_n;
  int first_re, last_re, first_hv, last_hv, hv_cnt, first_busy, flush_cyc, last_acc_cyc;
  logic [DW-1:0] acc_data [0:31];
  logic          acc_last [0:31];
  logic          prev_hold, prev_last, seen_busy, busy_s, flush_s;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  assign fifo_rdata = mem[read_ptr[AW-1:0]];

  ept_burst_drain_ctrl #(
    .ADDR_WIDTH (AW),
    .DEPTH      (1 << AW),
    .BURST      (BURST),
    .TIMEOUT    (TIMEOUT),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .write_ptr   (write_ptr),
    .read_ptr    (read_ptr),
    .read_enable (read_enable),
    .fifo_rdata  (fifo_rdata),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_last   (host_last),
    .flush_req   (flush_req),
    .flush       (flush),
    .burst_abort (burst_abort),
    .busy        (busy)
  );

  task automatic clear_log();
    cyc = 0; re_cnt = 0; held_re = 0; zero_re = 0; flush_cnt = 0; abort_cnt = 0;
    unstable = 0; stall_cnt = 0; acc_n = 0; hv_cnt = 0;
    first_re = -1; last_re = -1; first_hv = -1; last_hv = -1; first_busy = -1;
    flush_cyc = -1; last_acc_cyc = -1;
    prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
    seen_busy = 1'b0; busy_s = 1'b0; flush_s = 1'b0;
  endtask

  task automatic record();
    if (read_enable) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
      last_re = cyc;
      if (host_valid && !host_ready) held_re++;
      if (write_ptr == read_ptr) zero_re++;
    end
    if (host_valid) begin
      hv_cnt++;
      if (first_hv < 0) first_hv = cyc;
      last_hv = cyc;
    end
    if (host_valid && !host_ready) stall_cnt++;
    if (host_valid && host_ready) begin
      if (acc_n < 32) begin
        acc_data[acc_n] = host_data;
        acc_last[acc_n] = host_last;
      end
      acc_n++;
      last_acc_cyc = cyc;
    end
    if (prev_hold && (!host_valid || host_data !== prev_data || host_last !== prev_last))
      unstable++;
    prev_hold = host_valid && !host_ready;
    prev_data = host_data;
    prev_last = host_last;
    if (flush) begin
      flush_cnt++;
      flush_cyc = cyc;
    end
    if (burst_abort) abort_cnt++;
    if (busy && first_busy < 0) first_busy = cyc;
    if (busy) seen_busy = 1'b1;
    busy_s  = busy;
    flush_s = flush;
  endtask

  // Sample at the falling edge, then move to just after the next rising edge.
  // The FIFO write side obeys a flush pulse by zeroing its pointer.
  task automatic cycle();
    @(negedge clk);
    record();
    @(posedge clk);
    #1;
    cyc++;
    if (flush_s) write_ptr = '0;
  endtask

  task automatic push(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      mem[write_ptr[AW-1:0]] = base + DW'(i);
      write_ptr = write_ptr + 1'b1;
    end
  endtask

  task automatic run_until_idle(input int max_cycles, input string name);
    int n = 0;
    while (!(seen_busy && !busy_s) && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    if (!(seen_busy && !busy_s)) begin
      errors++;
      $display("FAIL %s_done: burst still active or never started after %0d cycles", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; host_ready = 1'b0; flush_req = 1'b0; write_ptr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read_ptr, host_data} !== '0) begin
      errors++;
      $display("FAIL reset_regs: read_ptr=%0h host_data=%0h, required 0/0", read_ptr, host_data);
    end
    checks++;
    if ({host_valid, host_last, flush, burst_abort, busy, read_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/last/flush/abort/busy/re=%b, required 000000",
               {host_valid, host_last, flush, burst_abort, busy, read_enable});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_full_burst();
    int bad = 0;
    clear_log();
    enable = 1'b1; host_ready = 1'b1;
    push(8, 8'h10);
    run_until_idle(40, "full");
    checks++;
    if (first_busy !== 1 || first_re !== 1) begin
      errors++;
      $display("FAIL full_start: busy at %0d re at %0d, required 1/1", first_busy, first_re);
    end
    checks++;
    if (re_cnt !== 8 || last_re !== 8) begin
      errors++;
      $display("FAIL full_reads: count %0d last at %0d, required 8 consecutive ending at 8", re_cnt, last_re);
    end
    checks++;
    if (hv_cnt !== 8 || first_hv !== 2 || last_hv !== 9) begin
      errors++;
      $display("FAIL full_valid: %0d cycles from %0d to %0d, required 8 from 2 to 9", hv_cnt, first_hv, last_hv);
    end
    for (int i = 0; i < 8; i++)
      if (acc_data[i] !== 8'h10 + i || acc_last[i] !== (i == 7)) bad++;
    checks++;
    if (acc_n !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL full_words: %0d accepted with %0d wrong, required 8 words 10..17 last on 8th", acc_n, bad);
    end
    checks++;
    if (read_ptr !== 5'd8 || busy !== 1'b0 || host_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_end: read_ptr=%0d busy=%b valid=%b, required 8/0/0", read_ptr, busy, host_valid);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    clear_log();
    push(3, 8'h20);
    run_until_idle(40, "timeout");
    // TIMEOUT edges bring the timer to TIMEOUT; the following edge starts the burst.
    checks++;
    if (first_busy !== TIMEOUT + 1 || first_re !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_start: busy at %0d re at %0d, required %0d", first_busy, first_re, TIMEOUT + 1);
    end
    for (int i = 0; i < 3; i++)
      if (acc_data[i] !== 8'h20 + i || acc_last[i] !== (i == 2)) bad++;
    checks++;
    if (re_cnt !== 3 || acc_n !== 3 || bad !== 0) begin
      errors++;
      $display("FAIL timeout_words: reads %0d accepted %0d wrong %0d, required 3/3/0", re_cnt, acc_n, bad);
    end
    checks++;
    if (read_ptr !== 5'd11) begin
      errors++;
      $display("FAIL timeout_ptr: read_ptr=%0d, required 11", read_ptr);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    int n = 0;
    clear_log();
    push(8, 8'h30);
    while (!(seen_busy && !busy_s) && n < 80) begin
      case (cyc % 4)
        1, 2:    host_ready = 1'b0;
        default: host_ready = 1'b1;
      endcase
      if (seen_busy) enable = 1'b0;
      cycle();
      n++;
    end
    checks++;
    if (!(seen_busy && !busy_s)) begin
      errors++;
      $display("FAIL stall_done: burst unfinished after %0d cycles", n);
    end
    for (int i = 0; i < 8; i++)
      if (acc_data[i] !== 8'h30 + i || acc_last[i] !== (i == 7)) bad++;
    checks++;
    if (acc_n !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL stall_words: %0d accepted with %0d wrong, required 8 words 30..37 last on 8th", acc_n, bad);
    end
    checks++;
    if (stall_cnt == 0 || unstable !== 0) begin
      errors++;
      $display("FAIL stall_hold: stalls %0d unstable %0d, required >0 and 0", stall_cnt, unstable);
    end
    checks++;
    if (re_cnt !== 8 || held_re !== 0) begin
      errors++;
      $display("FAIL stall_reads: reads %0d while held %0d, required 8/0", re_cnt, held_re);
    end
    checks++;
    if (read_ptr !== 5'b10011) begin
      errors++;
      $display("FAIL stall_ptr: read_ptr=%b, required 10011", read_ptr);
    end
    enable = 1'b1;
    host_ready = 1'b1;
  endtask

  task automatic test_flush_burst();
    int bad = 0;
    int n = 0;
    logic req_done = 1'b0;
    clear_log();
    push(8, 8'h40);
    while (!(seen_busy && !busy_s) && n < 40) begin
      if (!req_done && host_valid && host_data == 8'h43) begin
        flush_req = 1'b1; host_ready = 1'b0; req_done = 1'b1;
      end else begin
        flush_req = 1'b0; host_ready = 1'b1;
      end
      cycle();
      n++;
    end
    checks++;
    if (!(seen_busy && !busy_s) || !req_done) begin
      errors++;
      $display("FAIL flush_done: finished=%b requested=%b, required 1/1", seen_busy && !busy_s, req_done);
    end
    for (int i = 0; i < 4; i++)
      if (acc_data[i] !== 8'h40 + i || acc_last[i] !== 1'b0) bad++;
    checks++;
    if (acc_n !== 4 || re_cnt !== 4 || bad !== 0) begin
      errors++;
      $display("FAIL flush_words: accepted %0d reads %0d wrong %0d, required 4/4/0 with no last", acc_n, re_cnt, bad);
    end
    checks++;
    if (flush_cnt !== 1 || abort_cnt !== 1 || flush_cyc !== last_acc_cyc + 1) begin
      errors++;
      $display("FAIL flush_pulse: flush %0d abort %0d at %0d after accept at %0d, required 1/1 next cycle",
               flush_cnt, abort_cnt, flush_cyc, last_acc_cyc);
    end
    checks++;
    if (read_ptr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_ptr: read_ptr=%0d busy=%b, required 0/0", read_ptr, busy);
    end
  endtask

  task automatic test_flush_priority();
    clear_log();
    push(8, 8'h70);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    run_until_idle(10, "prio");
    checks++;
    if (re_cnt !== 0 || hv_cnt !== 0 || flush_cnt !== 1 || abort_cnt !== 0) begin
      errors++;
      $display("FAIL prio_flush: reads %0d valid %0d flush %0d abort %0d, required 0/0/1/0",
               re_cnt, hv_cnt, flush_cnt, abort_cnt);
    end
    checks++;
    if (read_ptr !== '0 || first_busy !== 1) begin
      errors++;
      $display("FAIL prio_ptr: read_ptr=%0d busy at %0d, required 0/1", read_ptr, first_busy);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    clear_log();
    push(14, 8'h60);
    run_until_idle(40, "wrap_pre1");
    clear_log();
    run_until_idle(40, "wrap_pre2");
    checks++;
    if (read_ptr !== 5'b01110) begin
      errors++;
      $display("FAIL wrap_preload: read_ptr=%b, required 01110", read_ptr);
    end
    clear_log();
    push(8, 8'h50);
    run_until_idle(40, "wrap");
    checks++;
    if (first_busy !== 1) begin
      errors++;
      $display("FAIL wrap_level: burst started at %0d, required 1 (level 8)", first_busy);
    end
    for (int i = 0; i < 8; i++)
      if (acc_data[i] !== 8'h50 + i || acc_last[i] !== (i == 7)) bad++;
    checks++;
    if (acc_n !== 8 || bad !== 0 || zero_re !== 0) begin
      errors++;
      $display("FAIL wrap_words: accepted %0d wrong %0d empty reads %0d, required 8/0/0", acc_n, bad, zero_re);
    end
    checks++;
    if (read_ptr !== 5'b10110) begin
      errors++;
      $display("FAIL wrap_ptr: read_ptr=%b, required 10110", read_ptr);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic mid_valid;
    clear_log();
    push(8, 8'h80);
    repeat (3) cycle();
    @(negedge clk);
    mid_valid = host_valid;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mid_valid !== 1'b1 || host_valid !== 1'b0 || busy !== 1'b0 || read_enable !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: valid before %b, valid/busy/re after %b%b%b, required 1 then 000",
               mid_valid, host_valid, busy, read_enable);
    end
    checks++;
    if ({read_ptr, host_data, host_last, flush, burst_abort} !== '0) begin
      errors++;
      $display("FAIL midrst_regs: read_ptr=%0h data=%0h last=%b flush=%b abort=%b, required all 0",
               read_ptr, host_data, host_last, flush, burst_abort);
    end
    write_ptr = '0;
    clear_log();
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (4) cycle();
    checks++;
    if (flush_cnt !== 0 || abort_cnt !== 0 || first_busy !== -1 || read_ptr !== '0) begin
      errors++;
      $display("FAIL midrst_quiet: flush %0d abort %0d busy at %0d read_ptr %0d, required 0/0/-1/0",
               flush_cnt, abort_cnt, first_busy, read_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_stall();
    test_flush_burst();
    test_flush_priority();
    test_wrap();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
